time_poll_master: RTL
=====================

TIME_POLL_MASTER -- requirements
Module: time_poll_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, Avalon-MM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Avalon-MM data width.
REQ-003 SHALL have parameter POLL_DIV, default 50000000, clk cycles between poll reads (min 4).
REQ-004 SHALL have parameter READ_LATENCY, default 1, fixed slave read latency in cycles after command acceptance.
REQ-005 SHALL have ports: clk in 1, sole clock; reset in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: avm_address out ADDR_WIDTH; avm_read out 1; avm_write out 1; avm_writedata out DATA_WIDTH; avm_readdata in DATA_WIDTH; avm_waitrequest in 1.
REQ-007 SHALL have ports: poll_enable in 1, allows periodic reads; set_req in 1, level request to write time; set_hours in 5; set_minutes in 6; set_seconds in 6.
REQ-008 SHALL have ports: set_ack out 1, one-cycle write-accepted pulse; hours out 5; minutes out 6; seconds out 6; time_valid out 1; busy out 1; range_err out 1, sticky.

Function
REQ-009 SHALL implement FSM IDLE, RD_CMD, RD_WAIT, WR_CMD; busy = 1 in any state other than IDLE.
REQ-010 SHALL run a down-counter from POLL_DIV-1 to 0, reload on wrap; at 0 with poll_enable=1 set a single poll_pending flag (repeated ticks do not accumulate).
REQ-011 SHALL, in IDLE, go to WR_CMD if set_req=1 (priority over poll), else to RD_CMD if poll_pending=1, else stay.
REQ-012 SHALL, on IDLE->WR_CMD, latch set_* and drive avm_write=1, avm_address=0, avm_writedata={11'h0,hours,2'h0,minutes,2'h0,seconds} packed from latched values.
REQ-013 SHALL hold address, writedata, read/write strobes stable while avm_waitrequest=1; a command is accepted on the first cycle with strobe=1 and avm_waitrequest=0.
REQ-014 SHALL, on write acceptance, deassert avm_write next cycle, pulse set_ack for exactly one cycle, return to IDLE.
REQ-015 SHALL, in RD_CMD, drive avm_read=1, avm_address=0; on acceptance clear poll_pending, deassert avm_read, enter RD_WAIT.
REQ-016 SHALL, in RD_WAIT, sample avm_readdata exactly READ_LATENCY cycles after the acceptance edge, then return to IDLE.
REQ-017 SHALL decode sampled word as hours=[20:16], minutes=[13:8], seconds=[5:0], update outputs one cycle after sampling and set time_valid=1.
REQ-018 SHALL keep set_req and poll ticks arriving while busy pending; set_req is serviced on the next IDLE cycle, never dropped while held high.
REQ-019 SHALL never assert avm_read and avm_write in the same cycle.
REQ-020 SHALL keep outputs unchanged when poll_enable=0, except set_* writes, which still proceed.

Reset
REQ-021 SHALL, while reset=1, force state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, set_ack=0, hours/minutes/seconds=0, time_valid=0, range_err=0, busy=0, poll_pending=0, counter=POLL_DIV-1.
REQ-022 SHALL abort any in-flight transaction on reset mid-operation; no set_ack and no output update for the aborted transaction.

Configuration
REQ-023 SHALL honour macro TPM_RANGE_CHECK_EN: when defined, a sampled word with hours>23, minutes>59 or seconds>59 leaves hours/minutes/seconds/time_valid unchanged and sets range_err=1 until reset.
REQ-024 SHALL, when TPM_RANGE_CHECK_EN is undefined, update outputs from every sampled word and tie range_err to 0.

Verification
REQ-025 SHALL cover: POLL_DIV=8, poll_enable=1, slave returns 0x000C_1E2D, waitrequest=0 -> hours=12, minutes=30, seconds=45, time_valid=1 within 3 cycles of read acceptance.
REQ-026 SHALL cover: set_req=1 with 23:59:58, waitrequest high 3 cycles -> avm_write held 4 cycles, writedata=0x0017_3B3A stable, set_ack pulses once after acceptance.
REQ-027 SHALL cover: set_req and poll tick in same IDLE cycle -> write issued first, then read, no read lost.
REQ-028 SHALL cover: TPM_RANGE_CHECK_EN defined, readdata=0x0018_0000 -> outputs unchanged, range_err=1; undefined -> hours=24, range_err=0.
REQ-029 SHALL cover: reset asserted during RD_WAIT -> all outputs at reset values next edge, FSM in IDLE, no capture after release.

Source files
------------

// File: rtl/time_poll_master.sv
// -----------------------------------------------------------------------------
// time_poll_master
//
// Avalon-MM master that keeps a local copy of a time-of-day register. It reads
// the register every POLL_DIV clock cycles while poll_enable is high. When
// set_req is high it writes a new time to the register.
//
// Register layout (address 0): hours [20:16], minutes [13:8], seconds [5:0].
//
// Parameters
//   ADDR_WIDTH    Avalon-MM address width
//   DATA_WIDTH    Avalon-MM data width (at least 21 bits)
//   POLL_DIV      clock cycles between poll reads (at least 4)
//   READ_LATENCY  fixed slave read latency after command acceptance (>= 1)
//
// Ports
//   clk, reset        sole clock, asynchronous active-high reset
//   avm_*             Avalon-MM master interface
//   poll_enable       allows the periodic reads
//   set_req           level request to write set_hours/minutes/seconds
//   set_ack           one-cycle pulse when the write has been accepted
//   hours/minutes/seconds, time_valid   last time read from the slave
//   busy              high while a bus transaction is in progress
//   range_err         sticky flag for an out-of-range sampled time
//
// Build option
//   TPM_RANGE_CHECK_EN  when defined, a sampled time with hours > 23,
//                       minutes > 59 or seconds > 59 is discarded and sets
//                       range_err. When it is undefined, every sampled word
//                       is taken and range_err is tied to 0.
// -----------------------------------------------------------------------------
module time_poll_master #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int POLL_DIV     = 50000000,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [DATA_WIDTH-1:0] avm_writedata,
   input  logic [DATA_WIDTH-1:0] avm_readdata,
   input  logic                  avm_waitrequest,
   input  logic                  poll_enable,
   input  logic                  set_req,
   input  logic [4:0]            set_hours,
   input  logic [5:0]            set_minutes,
   input  logic [5:0]            set_seconds,
   output logic                  set_ack,
   output logic [4:0]            hours,
   output logic [5:0]            minutes,
   output logic [5:0]            seconds,
   output logic                  time_valid,
   output logic                  busy,
   output logic                  range_err
);

   localparam int CNT_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_WAIT = 2'd2,
      WR_CMD  = 2'd3
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_div_cnt;
   logic                  r_poll_pending;
   logic [LAT_W-1:0]      r_lat_cnt;
   logic [ADDR_WIDTH-1:0] r_avm_address;
   logic                  r_avm_read;
   logic                  r_avm_write;
   logic [DATA_WIDTH-1:0] r_avm_writedata;
   logic                  r_set_ack;
   logic                  r_busy;
   logic [4:0]            r_hours_p0;
   logic [5:0]            r_minutes_p0;
   logic [5:0]            r_seconds_p0;
   logic                  r_vld_p0;
   logic [4:0]            r_hours;
   logic [5:0]            r_minutes;
   logic [5:0]            r_seconds;
   logic                  r_time_valid;

   logic                  w_tick;
   logic                  w_rd_accept;
   logic                  w_sample_ok;
   logic                  w_unused_rd;

   // Packs a time into the register layout, zero-filling the gaps.
   function automatic logic [DATA_WIDTH-1:0] pack_time(input logic [4:0] h,
                                                       input logic [5:0] m,
                                                       input logic [5:0] s);
      logic [31:0] w;
      w = {11'h0, h, 2'h0, m, 2'h0, s};
      return DATA_WIDTH'(w);
   endfunction

`ifdef TPM_RANGE_CHECK_EN
   function automatic logic time_in_range(input logic [4:0] h,
                                          input logic [5:0] m,
                                          input logic [5:0] s);
      return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
   endfunction
`endif

   assign w_tick      = (r_div_cnt == '0) && poll_enable;
   assign w_rd_accept = (r_state == RD_CMD) && !avm_waitrequest;
   // Only the time fields of the read word are used.
   assign w_unused_rd = ^avm_readdata;

`ifdef TPM_RANGE_CHECK_EN
   assign w_sample_ok = time_in_range(r_hours_p0, r_minutes_p0, r_seconds_p0);
`else
   assign w_sample_ok = 1'b1;
`endif

   // Poll timebase. Ticks collapse into a single pending flag. A tick that
   // lands on the read-accept edge keeps the flag set, so that tick is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt      <= CNT_W'(POLL_DIV - 1);
         r_poll_pending <= 1'b0;
      end else begin
         if (r_div_cnt == '0) begin
            r_div_cnt <= CNT_W'(POLL_DIV - 1);
         end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
         end
         if (w_tick) begin
            r_poll_pending <= 1'b1;
         end else if (w_rd_accept) begin
            r_poll_pending <= 1'b0;
         end
      end
   end

   // Bus FSM. A write has priority over a poll. A poll starts only while
   // poll_enable is high, so the time outputs stay frozen when polling is off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_avm_address   <= '0;
         r_avm_read      <= 1'b0;
         r_avm_write     <= 1'b0;
         r_avm_writedata <= '0;
         r_set_ack       <= 1'b0;
         r_busy          <= 1'b0;
         r_lat_cnt       <= '0;
         r_hours_p0      <= '0;
         r_minutes_p0    <= '0;
         r_seconds_p0    <= '0;
         r_vld_p0        <= 1'b0;
      end else begin
         r_set_ack <= 1'b0;
         r_vld_p0  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (set_req) begin
                  r_avm_address   <= '0;
                  r_avm_write     <= 1'b1;
                  r_avm_writedata <= pack_time(set_hours, set_minutes, set_seconds);
                  r_busy          <= 1'b1;
                  r_state         <= WR_CMD;
               end else if (r_poll_pending && poll_enable) begin
                  r_avm_address <= '0;
                  r_avm_read    <= 1'b1;
                  r_busy        <= 1'b1;
                  r_state       <= RD_CMD;
               end
            end
            WR_CMD: begin
               if (!avm_waitrequest) begin
                  r_avm_write <= 1'b0;
                  r_set_ack   <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            RD_CMD: begin
               if (!avm_waitrequest) begin
                  r_avm_read <= 1'b0;
                  r_lat_cnt  <= LAT_W'(READ_LATENCY - 1);
                  r_state    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // Data is valid READ_LATENCY edges after the accept edge.
               if (r_lat_cnt == '0) begin
                  r_hours_p0   <= avm_readdata[20:16];
                  r_minutes_p0 <= avm_readdata[13:8];
                  r_seconds_p0 <= avm_readdata[5:0];
                  r_vld_p0     <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ---- stage p0 -> output: decoded sample updates the visible time ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hours      <= '0;
         r_minutes    <= '0;
         r_seconds    <= '0;
         r_time_valid <= 1'b0;
      end else if (r_vld_p0 && w_sample_ok) begin
         r_hours      <= r_hours_p0;
         r_minutes    <= r_minutes_p0;
         r_seconds    <= r_seconds_p0;
         r_time_valid <= 1'b1;
      end
   end

`ifdef TPM_RANGE_CHECK_EN
   logic r_range_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_range_err <= 1'b0;
      end else if (r_vld_p0 && !w_sample_ok) begin
         r_range_err <= 1'b1;
      end
   end

   assign range_err = r_range_err;
`else
   assign range_err = 1'b0;
`endif

   assign avm_address   = r_avm_address;
   assign avm_read      = r_avm_read;
   assign avm_write     = r_avm_write;
   assign avm_writedata = r_avm_writedata;
   assign set_ack       = r_set_ack;
   assign busy          = r_busy;
   assign hours         = r_hours;
   assign minutes       = r_minutes;
   assign seconds       = r_seconds;
   assign time_valid    = r_time_valid;

endmodule
